// File: rtl/fetch_stage_pkg.sv
// Uop: shared fetch-stage types and the common depth bound for in-flight plus buffered work.
package Uop;

    localparam int FETCH_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] enc;
        logic        fault;
    } fetch_t;

endpackage

// File: rtl/fetch_stage_if.sv
// pipeline_if: valid/stall handshake between a producing stage and a consuming stage.
interface pipeline_if;

    logic valid;
    logic stall;

    modport Upstream (output valid, input stall);
    modport Downstream (input valid, output stall);

endinterface

// File: rtl/fetch_stage_buffer.sv
// fetch_buffer: generic 2-entry synchronous FIFO; flush wins over push/pop, caller never overflows it.
module fetch_buffer #(
    parameter type T = logic [31:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  T           din,
    output T           head,
    output logic [1:0] count
);

    T     mem [2];
    logic rd;
    logic wr;

    assign head = mem[rd];

    // storage, pointers and occupancy; storage is left alone by flush since count gates its use
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem   <= '{default: '0};
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= ~wr;
            end
            if (pop) rd <= ~rd;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: sequential-PC instruction fetch with two in-flight requests, a 2-entry uop buffer
// and execute redirects. Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import Uop::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    pipeline_if.Upstream d,
    output fetch_t      uopOut,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        imemRespErr,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic [31:0] perfStallCycles,
    output logic [31:0] perfEmptyCycles
);

    logic [31:0] pc;
    logic [1:0]  discard;
    logic [1:0]  outstanding;
    logic [1:0]  uop_count;
    logic [1:0]  pcq_count;
    logic [31:0] pcq_head;
    logic [2:0]  occupancy;
    logic        pop;
    logic        accept;
    logic        keep;
    logic        drop;
    fetch_t      uop_in;

    // requests still owed a response: live ones tracked by the pc queue plus those marked for discard
    assign outstanding = pcq_count + discard;
    assign pop         = d.valid && !d.stall;
    assign occupancy   = {1'b0, outstanding} + {1'b0, uop_count} - {2'b0, pop};
    assign imemReq     = rst && !redirectValid && (occupancy < 3'(DEPTH));
    assign imemAddr    = pc;
    assign accept      = imemReq && imemReady;
    assign keep        = imemRespValid && (discard == 2'd0);
    assign drop        = imemRespValid && (discard != 2'd0);
    assign uop_in      = {pcq_head, imemRespData, imemRespErr};
    assign d.valid     = uop_count != 2'd0;

    // fetch address and count of stale responses left over from a redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            discard <= 2'd0;
        end else if (redirectValid) begin
            pc      <= {redirectPc[31:2], 2'b00};
            discard <= outstanding - 2'(imemRespValid);
        end else begin
            if (accept) pc <= pc + 32'd4;
            if (drop) discard <= discard - 2'd1;
        end
    end

    fetch_buffer #(.T(logic [31:0])) pc_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirectValid),
        .push  (accept),
        .pop   (keep),
        .din   (pc),
        .head  (pcq_head),
        .count (pcq_count)
    );

    fetch_buffer #(.T(fetch_t)) uop_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirectValid),
        .push  (keep),
        .pop   (pop),
        .din   (uop_in),
        .head  (uopOut),
        .count (uop_count)
    );

`ifdef FETCH_PERF_EN
    // cycles where decode holds off a ready uop, and cycles with nothing to offer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perfStallCycles <= 32'd0;
            perfEmptyCycles <= 32'd0;
        end else begin
            if (d.valid && d.stall) perfStallCycles <= perfStallCycles + 32'd1;
            if (!d.valid) perfEmptyCycles <= perfEmptyCycles + 32'd1;
        end
    end
`else
    assign perfStallCycles = 32'd0;
    assign perfEmptyCycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle-scripted vectors for fetch_stage plus reset and wrap-around sequences.
module tb_fetch_stage;
    import Uop::*;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] rp;
        logic        err;
        logic        redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
        logic        efault;
    } vec_t;

`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd8;
    localparam logic [31:0] EXP_EMPTY = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
    localparam logic [31:0] EXP_EMPTY = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_if p1 ();
    pipeline_if p2 ();

    fetch_t      u1, u2;
    logic        req1, ready1, rv1, err1, redir1;
    logic        req2, ready2, rv2, err2, redir2;
    logic [31:0] addr1, rdata1, rpc1, ps1, pe1;
    logic [31:0] addr2, rdata2, rpc2, ps2, pe2;
    int          tests = 0;
    int          fails = 0;
    vec_t        vt [29];

    fetch_stage dut1 (
        .clk(clk), .rst(rst), .d(p1), .uopOut(u1),
        .imemReq(req1), .imemAddr(addr1), .imemReady(ready1),
        .imemRespValid(rv1), .imemRespData(rdata1), .imemRespErr(err1),
        .redirectValid(redir1), .redirectPc(rpc1),
        .perfStallCycles(ps1), .perfEmptyCycles(pe1)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .d(p2), .uopOut(u2),
        .imemReq(req2), .imemAddr(addr2), .imemReady(ready2),
        .imemRespValid(rv2), .imemRespData(rdata2), .imemRespErr(err2),
        .redirectValid(redir2), .redirectPc(rpc2),
        .perfStallCycles(ps2), .perfEmptyCycles(pe2)
    );

    function automatic logic [31:0] enc(input logic [31:0] p);
        return 32'hE000_0000 ^ p;
    endfunction

    function automatic vec_t mk(input logic st, input logic rdy, input logic rv, input logic [31:0] rp,
                                input logic er, input logic rd, input logic [31:0] rpc,
                                input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] p, input logic f);
        vec_t r;
        r.stall = st; r.ready = rdy; r.rv = rv; r.rp = rp; r.err = er; r.redir = rd; r.rpc = rpc;
        r.ereq = q; r.eaddr = a; r.evalid = v; r.epc = p; r.efault = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // stall ready rv rp err redir rpc | req addr valid pc fault
        vt[0]  = mk(0, 1, 0, 0,         0, 0, 0,         1, 32'h000, 0, 0,         0);
        vt[1]  = mk(0, 1, 1, 32'h000,   0, 0, 0,         1, 32'h004, 0, 0,         0);
        vt[2]  = mk(0, 1, 1, 32'h004,   1, 0, 0,         1, 32'h008, 1, 32'h000,   0);
        vt[3]  = mk(0, 1, 1, 32'h008,   0, 0, 0,         1, 32'h00C, 1, 32'h004,   1);
        vt[4]  = mk(1, 1, 1, 32'h00C,   0, 0, 0,         0, 32'h010, 1, 32'h008,   0);
        vt[5]  = mk(1, 1, 0, 0,         0, 0, 0,         0, 32'h010, 1, 32'h008,   0);
        vt[6]  = mk(1, 1, 0, 0,         0, 0, 0,         0, 32'h010, 1, 32'h008,   0);
        vt[7]  = mk(1, 1, 0, 0,         0, 0, 0,         0, 32'h010, 1, 32'h008,   0);
        vt[8]  = mk(1, 1, 0, 0,         0, 0, 0,         0, 32'h010, 1, 32'h008,   0);
        vt[9]  = mk(0, 1, 0, 0,         0, 0, 0,         1, 32'h010, 1, 32'h008,   0);
        vt[10] = mk(0, 1, 1, 32'h010,   0, 0, 0,         1, 32'h014, 1, 32'h00C,   0);
        vt[11] = mk(0, 1, 1, 32'h014,   0, 0, 0,         1, 32'h018, 1, 32'h010,   0);
        vt[12] = mk(0, 1, 0, 0,         0, 0, 0,         1, 32'h01C, 1, 32'h014,   0);
        vt[13] = mk(0, 1, 0, 0,         0, 1, 32'h103,   0, 32'h020, 0, 0,         0);
        vt[14] = mk(0, 1, 1, 32'h018,   0, 0, 0,         0, 32'h100, 0, 0,         0);
        vt[15] = mk(0, 1, 1, 32'h01C,   0, 0, 0,         1, 32'h100, 0, 0,         0);
        vt[16] = mk(0, 1, 1, 32'h100,   0, 0, 0,         1, 32'h104, 0, 0,         0);
        vt[17] = mk(0, 1, 1, 32'h104,   0, 0, 0,         1, 32'h108, 1, 32'h100,   0);
        vt[18] = mk(0, 1, 1, 32'h108,   0, 1, 32'h203,   0, 32'h10C, 1, 32'h104,   0);
        vt[19] = mk(0, 1, 0, 0,         0, 1, 32'h300,   0, 32'h200, 0, 0,         0);
        vt[20] = mk(0, 0, 0, 0,         0, 0, 0,         1, 32'h300, 0, 0,         0);
        vt[21] = mk(0, 1, 0, 0,         0, 0, 0,         1, 32'h300, 0, 0,         0);
        vt[22] = mk(0, 1, 1, 32'h300,   0, 0, 0,         1, 32'h304, 0, 0,         0);
        vt[23] = mk(1, 1, 1, 32'h304,   0, 0, 0,         0, 32'h308, 1, 32'h300,   0);
        vt[24] = mk(1, 1, 0, 0,         0, 0, 0,         0, 32'h308, 1, 32'h300,   0);
        vt[25] = mk(1, 1, 0, 0,         0, 0, 0,         0, 32'h308, 1, 32'h300,   0);
        vt[26] = mk(0, 1, 0, 0,         0, 0, 0,         1, 32'h308, 1, 32'h300,   0);
        vt[27] = mk(0, 1, 1, 32'h308,   0, 0, 0,         1, 32'h30C, 1, 32'h304,   0);
        vt[28] = mk(0, 1, 0, 0,         0, 0, 0,         1, 32'h310, 1, 32'h308,   0);

        p1.stall = 0; ready1 = 0; rv1 = 0; rdata1 = 0; err1 = 0; redir1 = 0; rpc1 = 0;
        p2.stall = 0; ready2 = 0; rv2 = 0; rdata2 = 0; err2 = 0; redir2 = 0; rpc2 = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset valid", 32'(p1.valid), 32'd0);
        check("reset uop pc", u1.pc, 32'd0);
        check("reset uop enc", u1.enc, 32'd0);
        check("reset req", 32'(req1), 32'd0);
        check("reset req2", 32'(req2), 32'd0);
        check("reset perf stall", ps1, 32'd0);
        check("reset perf empty", pe1, 32'd0);

        rst = 1'b1;
        for (int i = 0; i < 29; i++) begin
            p1.stall = vt[i].stall;
            ready1   = vt[i].ready;
            rv1      = vt[i].rv;
            rdata1   = enc(vt[i].rp);
            err1     = vt[i].err;
            redir1   = vt[i].redir;
            rpc1     = vt[i].rpc;
            #1;
            check($sformatf("r%0d req", i), 32'(req1), 32'(vt[i].ereq));
            check($sformatf("r%0d addr", i), addr1, vt[i].eaddr);
            check($sformatf("r%0d valid", i), 32'(p1.valid), 32'(vt[i].evalid));
            if (vt[i].evalid) begin
                check($sformatf("r%0d pc", i), u1.pc, vt[i].epc);
                check($sformatf("r%0d enc", i), u1.enc, enc(vt[i].epc));
                check($sformatf("r%0d fault", i), 32'(u1.fault), 32'(vt[i].efault));
            end
            @(negedge clk);
        end

        check("perf stall", ps1, EXP_STALL);
        check("perf empty", pe1, EXP_EMPTY);

        p1.stall = 1; rv1 = 1; rdata1 = enc(32'h30C); err1 = 0; redir1 = 0;
        #1 check("full req", 32'(req1), 32'd0);
        @(negedge clk);
        rv1 = 0; ready1 = 0;
        #1;
        check("pre-reset valid", 32'(p1.valid), 32'd1);
        check("pre-reset pc", u1.pc, 32'h30C);
        rst = 1'b0;
        #1;
        check("mid reset valid", 32'(p1.valid), 32'd0);
        check("mid reset uop pc", u1.pc, 32'd0);
        check("mid reset uop enc", u1.enc, 32'd0);
        check("mid reset req", 32'(req1), 32'd0);
        check("mid reset perf empty", pe1, 32'd0);
        p1.stall = 0;

        @(negedge clk);
        rst = 1'b1; ready2 = 1;
        #1;
        check("wrap c0 req", 32'(req2), 32'd1);
        check("wrap c0 addr", addr2, 32'hFFFF_FFF8);
        @(negedge clk);
        rv2 = 1; rdata2 = enc(32'hFFFF_FFF8);
        #1;
        check("wrap c1 req", 32'(req2), 32'd1);
        check("wrap c1 addr", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        rdata2 = enc(32'hFFFF_FFFC);
        #1;
        check("wrap c2 req", 32'(req2), 32'd1);
        check("wrap c2 addr", addr2, 32'h0000_0000);
        check("wrap c2 valid", 32'(p2.valid), 32'd1);
        check("wrap c2 pc", u2.pc, 32'hFFFF_FFF8);
        check("wrap c2 enc", u2.enc, enc(32'hFFFF_FFF8));
        @(negedge clk);
        rv2 = 0;
        #1;
        check("wrap c3 pc", u2.pc, 32'hFFFF_FFFC);
        check("wrap c3 addr", addr2, 32'h0000_0004);
        check("idle dut1 req", 32'(req1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
